// File: rtl/mem_req_arbiter_pkg.sv
// rtl/mem_req_arbiter_pkg.sv - shared types and constants for the memory request arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    RESP     = 2'd2
  } state_t;

  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

  // Index width for a port count; a single port still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// rtl/mem_req_arbiter_if.sv - requester and memory side signals of the arbiter
interface mem_req_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  localparam int GW = id_width(NUM_PORTS);

  logic [NUM_PORTS-1:0]        req_valid;
  logic [NUM_PORTS-1:0]        req_rd_wr;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr;
  logic [NUM_PORTS*DATA_W-1:0] req_wr_data;
  logic [NUM_PORTS-1:0]        req_ack;
  logic                        req_err;
  logic [DATA_W-1:0]           req_rd_data;
  logic                        mem_req_valid;
  logic                        mem_rd_wr;
  logic [ADDR_W-1:0]           mem_rd_addr;
  logic [ADDR_W-1:0]           mem_wr_addr;
  logic [DATA_W-1:0]           mem_wr_data;
  logic [DATA_W-1:0]           mem_rd_data;
  logic                        mem_ack;
  logic                        busy;
  logic [GW-1:0]               grant_id;

  modport slave (
    input  req_valid, req_rd_wr, req_addr, req_wr_data, mem_rd_data, mem_ack,
    output req_ack, req_err, req_rd_data, mem_req_valid, mem_rd_wr,
           mem_rd_addr, mem_wr_addr, mem_wr_data, busy, grant_id
  );

  modport master (
    output req_valid, req_rd_wr, req_addr, req_wr_data, mem_rd_data, mem_ack,
    input  req_ack, req_err, req_rd_data, mem_req_valid, mem_rd_wr,
           mem_rd_addr, mem_wr_addr, mem_wr_data, busy, grant_id
  );

endinterface

// File: rtl/mem_req_arbiter_rr_arbiter.sv
// rtl/mem_req_arbiter_rr_arbiter.sv - combinational round-robin port picker
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int GW        = id_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [GW-1:0]        rr_ptr,
  output logic [GW-1:0]        grant,
  output logic                 grant_valid
);

  // First pass finds a requester at or after rr_ptr; second pass wraps to the lowest index.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!grant_valid && req[i] && (GW'(i) >= rr_ptr)) begin
        grant       = GW'(i);
        grant_valid = 1'b1;
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!grant_valid && req[i]) begin
        grant       = GW'(i);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - round-robin front-end sharing one memory port among requesters
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic              clk,
  input logic              reset,
  mem_req_arbiter_if.slave bus
);

  localparam int GW = id_width(NUM_PORTS);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t            state_q, state_d;
  logic [GW-1:0]     rr_ptr_q;
  logic [GW-1:0]     grant_q;
  logic              dir_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [CW-1:0]     cnt_q;

  logic [GW-1:0]     arb_grant;
  logic              arb_valid;
  logic              sel_dir;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              timeout_hit;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS), .GW(GW)) u_rr (
    .req         (bus.req_valid),
    .rr_ptr      (rr_ptr_q),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES));

  // Pick the winning port's direction, address and write data.
  always_comb begin
    sel_dir   = MEM_RD;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (arb_grant == GW'(i)) begin
        sel_dir   = bus.req_rd_wr[i];
        sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.req_wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; late or stray mem_ack outside WAIT_ACK has no effect.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (arb_valid) state_d = WAIT_ACK;
      WAIT_ACK: if (bus.mem_ack || timeout_hit) state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Transaction registers: latch the request, count wait cycles, capture the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
      grant_q  <= '0;
      dir_q    <= MEM_RD;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arb_valid) begin
            grant_q <= arb_grant;
            dir_q   <= sel_dir;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= CW'(1);
          end
        end
        WAIT_ACK: begin
          if (bus.mem_ack) begin
            rdata_q <= (dir_q == MEM_RD) ? bus.mem_rd_data : '0;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          rr_ptr_q <= (grant_q == GW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
          cnt_q    <= '0;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state only; everything idles at zero.
  always_comb begin
    bus.busy          = (state_q != IDLE);
    bus.grant_id      = grant_q;
    bus.mem_req_valid = 1'b0;
    bus.mem_rd_wr     = MEM_RD;
    bus.mem_rd_addr   = '0;
    bus.mem_wr_addr   = '0;
    bus.mem_wr_data   = '0;
    bus.req_ack       = '0;
    bus.req_err       = 1'b0;
    bus.req_rd_data   = '0;
    if (state_q == WAIT_ACK) begin
      bus.mem_req_valid = 1'b1;
      bus.mem_rd_wr     = dir_q;
      if (dir_q == MEM_WR) begin
        bus.mem_wr_addr = addr_q;
        bus.mem_wr_data = wdata_q;
      end else begin
        bus.mem_rd_addr = addr_q;
      end
    end
    if (state_q == RESP) begin
      bus.req_ack[grant_q] = 1'b1;
      bus.req_err          = err_q;
      bus.req_rd_data      = rdata_q;
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - self-checking bench for mem_req_arbiter
module tb_mem_req_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 8;

  typedef struct {
    int          port;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  typedef struct {
    int          port;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_at;
    logic [31:0] rdata;
    bit          exp_err;
    int          exp_lat;
    bit          late;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  mem_req_arbiter_if #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_req_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ack_count = 0;
  int          last_ack_cyc = 0;
  int          wcnt = 0;
  int          ack_at = 0;
  bit          inject_ack = 0;
  bit          hold_req = 0;
  logic [31:0] rdata_cfg = '0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample outputs at negedge, score acks, then run the memory model.
  task automatic cycle();
    exp_t e;
    int   p;
    bit   model_ack;
    @(negedge clk);
    cyc++;
    if (bus.req_ack != '0) begin
      ack_count++;
      last_ack_cyc = cyc;
      check("ack_onehot", 160'($countones(bus.req_ack)), 160'd1);
      check("mem_req_valid_in_resp", 160'(bus.mem_req_valid), 160'd0);
      p = bus.req_ack[1] ? 1 : 0;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got %0b expected none", bus.req_ack);
      end else begin
        e = sb.pop_front();
        check("ack_port", 160'(p), 160'(e.port));
        check("ack_err", 160'(bus.req_err), 160'(e.err));
        if (!e.err) check("ack_rd_data", 160'(bus.req_rd_data), 160'(e.rdata));
      end
      if (!hold_req) bus.req_valid[p] = 1'b0;
    end
    model_ack = 1'b0;
    if (bus.mem_req_valid) begin
      wcnt++;
      if (wcnt == 1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mem_req: got grant %0d expected none", bus.grant_id);
        end else begin
          e = sb[0];
          check("grant_id", 160'(bus.grant_id), 160'(e.port));
          check("mem_rd_wr", 160'(bus.mem_rd_wr), 160'(e.wr));
          check("mem_rd_addr", 160'(bus.mem_rd_addr), e.wr ? 160'd0 : 160'(e.addr));
          check("mem_wr_addr", 160'(bus.mem_wr_addr), e.wr ? 160'(e.addr) : 160'd0);
          if (e.wr) check("mem_wr_data", 160'(bus.mem_wr_data), 160'(e.wdata));
        end
      end
      model_ack = (ack_at != 0) && (wcnt == ack_at);
    end else begin
      wcnt = 0;
    end
    bus.mem_ack     = model_ack || inject_ack;
    bus.mem_rd_data = bus.mem_ack ? rdata_cfg : $urandom();
  endtask

  task automatic wait_acks(input int n, input int budget);
    int b = 0;
    while (ack_count < n && b < budget) begin
      cycle();
      b++;
    end
    if (ack_count < n) begin
      checks++;
      errors++;
      $display("FAIL ack_wait: got %0d acks expected %0d", ack_count, n);
    end
  endtask

  task automatic drive_port(input int port, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_rd_wr[port]            = wr;
    bus.req_addr[port*AW +: AW]    = addr;
    bus.req_wr_data[port*DW +: DW] = wdata;
    bus.req_valid[port]            = 1'b1;
  endtask

  task automatic push_exp(input int port, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input bit err);
    exp_t e;
    e.port  = port;
    e.wr    = wr;
    e.addr  = addr;
    e.wdata = wdata;
    e.rdata = wr ? 32'h0 : rdata;
    e.err   = err;
    sb.push_back(e);
  endtask

  vec_t vecs[6];

  initial begin
    int c0;
    int n0;
    int prev;

    vecs[0] = '{0, 1'b0, 32'h0000_0100, 32'h0,         2, 32'hDEAD_BEEF, 1'b0, 3, 1'b0};
    vecs[1] = '{1, 1'b1, 32'h0000_0040, 32'h1234_5678, 1, 32'hFFFF_0000, 1'b0, 2, 1'b0};
    vecs[2] = '{1, 1'b0, 32'h2000_0004, 32'h0,         8, 32'hCAFE_F00D, 1'b0, 9, 1'b0};
    vecs[3] = '{0, 1'b1, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 0, 32'h0,         1'b1, 9, 1'b1};
    vecs[4] = '{0, 1'b0, 32'h0000_0008, 32'h0,         9, 32'h0000_0077, 1'b1, 9, 1'b0};
    vecs[5] = '{1, 1'b0, 32'h0000_0000, 32'h0,         5, 32'h0000_0001, 1'b0, 6, 1'b0};

    reset           = 1'b1;
    bus.req_valid   = '0;
    bus.req_rd_wr   = '0;
    bus.req_addr    = '0;
    bus.req_wr_data = '0;
    bus.mem_ack     = 1'b0;
    bus.mem_rd_data = '0;

    cycle();
    cycle();
    check("reset_outputs", 160'({bus.req_ack, bus.req_err, bus.req_rd_data, bus.mem_req_valid,
          bus.mem_rd_wr, bus.mem_rd_addr, bus.mem_wr_addr, bus.mem_wr_data, bus.busy, bus.grant_id}), 160'd0);
    reset = 1'b0;
    cycle();
    check("idle_busy", 160'(bus.busy), 160'd0);

    for (int i = 0; i < 6; i++) begin
      push_exp(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].exp_err);
      ack_at    = vecs[i].ack_at;
      rdata_cfg = vecs[i].rdata;
      drive_port(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      c0 = cyc;
      n0 = ack_count;
      wait_acks(n0 + 1, 40);
      check("latency", 160'(last_ack_cyc - c0), 160'(vecs[i].exp_lat));
      if (vecs[i].late) begin
        n0 = ack_count;
        cycle();
        inject_ack = 1'b1;
        cycle();
        inject_ack = 1'b0;
        cycle();
        cycle();
        check("late_ack_no_resp", 160'(ack_count - n0), 160'd0);
        check("late_ack_busy", 160'(bus.busy), 160'd0);
      end
      cycle();
    end

    // Reset during WAIT_ACK: rr_ptr is 1 after serving port 0, reset must return it to 0.
    push_exp(0, 1'b0, 32'h0000_0300, 32'h0, 32'h1111_2222, 1'b0);
    ack_at    = 1;
    rdata_cfg = 32'h1111_2222;
    drive_port(0, 1'b0, 32'h0000_0300, 32'h0);
    wait_acks(ack_count + 1, 20);
    cycle();
    push_exp(1, 1'b0, 32'h0000_0600, 32'h0, 32'h0, 1'b0);
    ack_at = 0;
    drive_port(1, 1'b0, 32'h0000_0600, 32'h0);
    cycle();
    cycle();
    cycle();
    check("mid_busy", 160'(bus.busy), 160'd1);
    n0    = ack_count;
    reset = 1'b1;
    drive_port(0, 1'b0, 32'h0000_0500, 32'h0);
    cycle();
    check("mid_reset_outputs", 160'({bus.req_ack, bus.req_err, bus.req_rd_data, bus.mem_req_valid,
          bus.mem_rd_wr, bus.mem_rd_addr, bus.mem_wr_addr, bus.mem_wr_data, bus.busy, bus.grant_id}), 160'd0);
    check("mid_reset_no_ack", 160'(ack_count - n0), 160'd0);
    sb.delete();
    reset     = 1'b0;
    ack_at    = 2;
    rdata_cfg = 32'h0BAD_F00D;
    push_exp(0, 1'b0, 32'h0000_0500, 32'h0, 32'h0BAD_F00D, 1'b0);
    push_exp(1, 1'b0, 32'h0000_0600, 32'h0, 32'h0BAD_F00D, 1'b0);
    wait_acks(ack_count + 2, 40);
    cycle();

    // Fairness: both ports hold requests, memory acks at wait count 1.
    hold_req  = 1'b1;
    ack_at    = 1;
    rdata_cfg = 32'h55AA_33CC;
    for (int k = 0; k < 6; k++) push_exp(k % 2, 1'b0, 32'h1000 + 32'(k % 2) * 4, 32'h0, 32'h55AA_33CC, 1'b0);
    drive_port(0, 1'b0, 32'h0000_1000, 32'h0);
    drive_port(1, 1'b0, 32'h0000_1004, 32'h0);
    n0 = ack_count;
    for (int k = 0; k < 6; k++) begin
      prev = last_ack_cyc;
      wait_acks(n0 + k + 1, 20);
      if (k > 0) check("fair_spacing", 160'(last_ack_cyc - prev), 160'd3);
    end
    hold_req      = 1'b0;
    bus.req_valid = '0;
    cycle();
    cycle();
    check("fair_drained", 160'(sb.size()), 160'd0);

    // Spurious ack while idle.
    n0         = ack_count;
    inject_ack = 1'b1;
    cycle();
    inject_ack = 1'b0;
    cycle();
    cycle();
    check("spurious_busy", 160'(bus.busy), 160'd0);
    check("spurious_no_ack", 160'(ack_count - n0), 160'd0);
    check("spurious_no_mem_req", 160'(bus.mem_req_valid), 160'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
